reaction_round_controller: RTL and testbench
============================================

Name: reaction_round_controller

Overview:
Session sequencer for the reaction-time benchmark. It runs NUM_ROUNDS rounds, each with a pseudo-random foreperiod and a stimulus. It drives the millisecond timer datapath through clear/run controls and captures the elapsed count when the user responds. It detects false starts and timeouts, tracks the best time, and sits between the push-button inputs and the timer/display datapath.

Parameters:
CLK_PER_MS, 50, clk cycles per millisecond tick (>=2)
MIN_DELAY_MS, 1000, fixed part of foreperiod in ms
RAND_BITS, 12, random foreperiod component = lfsr[RAND_BITS-1:0] ms (1..16)
NUM_ROUNDS, 4, rounds per session (1..7; power of 2 when AVERAGE_EN)
TIMEOUT_MS, 9999, meas_ms value that aborts a round
GAP_MS, 500, pause between rounds in ms

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start_trigger  in  1  session start/restart button, level
user_trigger  in  1  user response button, level
meas_ms  in  14  elapsed ms from timer datapath
meas_clear  out  1  one-cycle pulse: zero the timer datapath
meas_run  out  1  timer counts while high
stimulus_on  out  1  stimulus LED
result_ms  out  14  last captured reaction time
result_valid  out  1  one-cycle pulse when result_ms updates
best_ms  out  14  minimum valid result this session
round_idx  out  3  current round, 0-based
false_start  out  1  sticky flag, round aborted by early press
timeout  out  1  sticky flag, round aborted by no press
busy  out  1  high in every state except IDLE, DONE, FAULT
done  out  1  high in DONE

Behaviour:
- Reset values: all outputs 0, except best_ms = 14'h3FFF. State IDLE, LFSR = 16'hACE1, edge registers 0.
- Inputs are edge-detected internally with a registered previous value. Only a 0->1 transition counts. A button held across a state change does not retrigger.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every clk, including in IDLE. Never reset except by rst.
- ms tick: prescaler 0..CLK_PER_MS-1. Cleared on entry to FOREPERIOD and GAP. Tick asserts when it wraps.
- IDLE: on start edge -> ARM. In the same cycle: round_idx=0, best_ms=3FFF, flags cleared.
- ARM (1 cycle): delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0]. Pulse meas_clear. Go to FOREPERIOD.
- FOREPERIOD: decrement delay_cnt on each tick.
  - delay_cnt reaching 0 -> REACT.
  - A user edge before that -> FAULT with false_start=1. The user edge has priority over expiry in the same cycle.
- REACT: stimulus_on=1 and meas_run=1 (both registered, asserted from the first REACT cycle).
  - User edge -> CAPTURE.
  - meas_ms >= TIMEOUT_MS with no edge -> FAULT with timeout=1. The user edge has priority.
- CAPTURE (1 cycle): meas_run=0, stimulus_on=0.
  - result_ms = meas_ms, result_valid pulse.
  - best_ms = min(best_ms, meas_ms).
  - If round_idx == NUM_ROUNDS-1 -> DONE; otherwise round_idx+1 and -> GAP.
- GAP: count GAP_MS ticks, then -> ARM. User edges are ignored.
- FAULT: meas_run=0, stimulus_on=0. On start edge -> ARM, repeating the same round_idx; flags clear on exit.
- DONE: outputs hold. On start edge -> ARM as a new session (same clears as from IDLE).
- start edge in FOREPERIOD, REACT, GAP or CAPTURE is ignored.
- rst mid-round: next cycle is IDLE, all outputs at reset values. meas_run drops within 1 cycle.
- meas_ms is treated as saturating by the datapath. The controller does no arithmetic on it except the compare and min.

Optional Feature:
AVERAGE_EN
- When defined: adds output avg_ms[13:0] (reset 0) and a 17-bit sum register.
  - Sum is cleared on session start and adds meas_ms in each CAPTURE.
  - On entry to DONE, avg_ms = sum >> log2(NUM_ROUNDS), truncating.
  - Faulted rounds do not contribute.
- When undefined: the port and register are absent, and behaviour is otherwise identical.

Test Plan:
All scenarios use CLK_PER_MS=4, MIN_DELAY_MS=2, RAND_BITS=2, NUM_ROUNDS=4, TIMEOUT_MS=20, GAP_MS=2, with meas_ms driven by a bench model counting ms while meas_run=1.

1. Normal session: start pulse, then a user press 10 ms after each stimulus_on rise -> 4 result_valid pulses with result_ms=10; after the last, best_ms=10, done=1, round_idx=3.
2. Best tracking: press latencies 12, 7, 15, 9 ms -> best_ms sequence 12, 7, 7, 7; AVERAGE_EN avg_ms=10 (43>>2).
3. False start: press during FOREPERIOD of round 1 -> false_start=1, stimulus_on never rises, round_idx stays 1; start pulse -> round 1 reruns and false_start clears.
4. Timeout: no press after stimulus -> at meas_ms=20, timeout=1, meas_run=0, no result_valid pulse.
5. Held button: user_trigger held high from FOREPERIOD entry through stimulus -> no false_start (no edge during FOREPERIOD), no capture until a release and re-press.
6. Reset mid-REACT: assert rst for 1 cycle -> next cycle state IDLE, meas_run=0, stimulus_on=0, best_ms=3FFF; a following start edge begins round 0.

Source files
------------

// File: rtl/reaction_round_controller.sv
// Session sequencer for the reaction-time benchmark: foreperiod, stimulus, capture, best-time tracking.
// Optional AVERAGE_EN macro adds avg_ms, the truncated mean of the session's captured times.
module reaction_round_controller #(
  parameter int CLK_PER_MS   = 50,
  parameter int MIN_DELAY_MS = 1000,
  parameter int RAND_BITS    = 12,
  parameter int NUM_ROUNDS   = 4,
  parameter int TIMEOUT_MS   = 9999,
  parameter int GAP_MS       = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_trigger,
  input  logic        user_trigger,
  input  logic [13:0] meas_ms,
  output logic        meas_clear,
  output logic        meas_run,
  output logic        stimulus_on,
  output logic [13:0] result_ms,
  output logic        result_valid,
  output logic [13:0] best_ms,
  output logic [2:0]  round_idx,
  output logic        false_start,
  output logic        timeout,
  output logic        busy,
  output logic        done
`ifdef AVERAGE_EN
  ,
  output logic [13:0] avg_ms
`endif
);

  localparam int PW = (CLK_PER_MS > 2) ? $clog2(CLK_PER_MS) : 1;
  localparam int DW = 17;

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] ARM        = 3'd1;
  localparam logic [2:0] FOREPERIOD = 3'd2;
  localparam logic [2:0] REACT      = 3'd3;
  localparam logic [2:0] CAPTURE    = 3'd4;
  localparam logic [2:0] GAP        = 3'd5;
  localparam logic [2:0] FAULT      = 3'd6;
  localparam logic [2:0] DONE       = 3'd7;

  function automatic logic [13:0] min14(input logic [13:0] a, input logic [13:0] b);
    return (b < a) ? b : a;
  endfunction

  logic [2:0]    state;
  logic [15:0]   lfsr;
  logic          start_prev, user_prev;
  logic [PW-1:0] presc;
  logic [DW-1:0] delay_cnt, gap_cnt;
  logic          start_edge, user_edge, tick, last_round;

  assign start_edge = start_trigger & ~start_prev;
  assign user_edge  = user_trigger & ~user_prev;
  assign tick       = (presc == PW'(CLK_PER_MS - 1));
  assign last_round = (round_idx == 3'(NUM_ROUNDS - 1));

  assign meas_clear = (state == ARM);
  assign busy       = (state != IDLE) && (state != DONE) && (state != FAULT);
  assign done       = (state == DONE);

`ifdef AVERAGE_EN
  localparam int LOG_N = $clog2(NUM_ROUNDS);
  logic [16:0] sum;
  logic [16:0] sum_next;
  assign sum_next = sum + 17'(meas_ms);
`endif

  // Free-running Galois LFSR and input edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= 16'hACE1;
      start_prev <= 1'b0;
      user_prev  <= 1'b0;
    end else begin
      lfsr       <= (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      start_prev <= start_trigger;
      user_prev  <= user_trigger;
    end
  end

  // ms prescaler restarts whenever a timed state (FOREPERIOD or GAP) is about to begin
  always_ff @(posedge clk) begin
    if (rst || state == ARM || state == CAPTURE) presc <= '0;
    else if (tick)                               presc <= '0;
    else                                         presc <= presc + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      stimulus_on  <= 1'b0;
      meas_run     <= 1'b0;
      result_ms    <= '0;
      result_valid <= 1'b0;
      best_ms      <= 14'h3FFF;
      round_idx    <= '0;
      false_start  <= 1'b0;
      timeout      <= 1'b0;
      delay_cnt    <= '0;
      gap_cnt      <= '0;
`ifdef AVERAGE_EN
      sum          <= '0;
      avg_ms       <= '0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_edge) begin
            state       <= ARM;
            round_idx   <= '0;
            best_ms     <= 14'h3FFF;
            false_start <= 1'b0;
            timeout     <= 1'b0;
`ifdef AVERAGE_EN
            sum         <= '0;
`endif
          end
        end
        ARM: begin
          delay_cnt <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
          state     <= FOREPERIOD;
        end
        FOREPERIOD: begin
          if (user_edge) begin
            state       <= FAULT;
            false_start <= 1'b1;
          end else if (tick) begin
            delay_cnt <= delay_cnt - 1'b1;
            if (delay_cnt == DW'(1)) begin
              state       <= REACT;
              stimulus_on <= 1'b1;
              meas_run    <= 1'b1;
            end
          end
        end
        REACT: begin
          if (user_edge) begin
            state       <= CAPTURE;
            stimulus_on <= 1'b0;
            meas_run    <= 1'b0;
          end else if (meas_ms >= 14'(TIMEOUT_MS)) begin
            state       <= FAULT;
            timeout     <= 1'b1;
            stimulus_on <= 1'b0;
            meas_run    <= 1'b0;
          end
        end
        CAPTURE: begin
          result_ms    <= meas_ms;
          result_valid <= 1'b1;
          best_ms      <= min14(best_ms, meas_ms);
`ifdef AVERAGE_EN
          sum          <= sum_next;
`endif
          if (last_round) begin
            state <= DONE;
`ifdef AVERAGE_EN
            avg_ms <= 14'(sum_next >> LOG_N);
`endif
          end else begin
            round_idx <= round_idx + 1'b1;
            gap_cnt   <= DW'(GAP_MS);
            state     <= GAP;
          end
        end
        GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt - 1'b1;
            if (gap_cnt == DW'(1)) state <= ARM;
          end
        end
        FAULT: begin
          if (start_edge) begin
            state       <= ARM;
            false_start <= 1'b0;
            timeout     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_round_controller.sv
// Bench for reaction_round_controller: timer model, result scoreboard, table-driven rounds plus corner sequences.
module tb_reaction_round_controller;

  logic        clk = 1'b0;
  logic        rst, start_trigger, user_trigger;
  logic [13:0] meas_ms;
  logic        meas_clear, meas_run, stimulus_on, result_valid;
  logic [13:0] result_ms, best_ms;
  logic [2:0]  round_idx;
  logic        false_start, timeout, busy, done;
`ifdef AVERAGE_EN
  logic [13:0] avg_ms;
`endif

  always #5 clk = ~clk;

  reaction_round_controller #(
    .CLK_PER_MS(4), .MIN_DELAY_MS(2), .RAND_BITS(2),
    .NUM_ROUNDS(4), .TIMEOUT_MS(20), .GAP_MS(2)
  ) dut (
    .clk(clk), .rst(rst), .start_trigger(start_trigger), .user_trigger(user_trigger),
    .meas_ms(meas_ms), .meas_clear(meas_clear), .meas_run(meas_run),
    .stimulus_on(stimulus_on), .result_ms(result_ms), .result_valid(result_valid),
    .best_ms(best_ms), .round_idx(round_idx), .false_start(false_start),
    .timeout(timeout), .busy(busy), .done(done)
`ifdef AVERAGE_EN
    , .avg_ms(avg_ms)
`endif
  );

  typedef struct { int lat; logic [13:0] res; logic [13:0] best; } rec_t;
  typedef struct { logic [13:0] res; logic [13:0] best; } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Timer datapath model: counts ms while meas_run, saturating
  logic [1:0] tpre;
  always @(posedge clk) begin
    if (rst || meas_clear) begin
      tpre    <= 2'd0;
      meas_ms <= 14'd0;
    end else if (meas_run) begin
      if (tpre == 2'd3) begin
        tpre <= 2'd0;
        if (meas_ms != 14'h3FFF) meas_ms <= meas_ms + 14'd1;
      end else begin
        tpre <= tpre + 2'd1;
      end
    end
  end

  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("result_ms", 32'(result_ms), 32'(mon_e.res));
        check("best_ms", 32'(best_ms), 32'(mon_e.best));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk) start_trigger = 1'b1;
    @(negedge clk) start_trigger = 1'b0;
  endtask

  task automatic wait_stim();
    int i;
    for (i = 0; i < 300 && !stimulus_on; i++) @(negedge clk);
    if (!stimulus_on) check("stimulus_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic press_at(input int lat);
    for (int i = 0; i < 400 && meas_ms < 14'(lat); i++) @(negedge clk);
    user_trigger = 1'b1;
    cyc(2);
    user_trigger = 1'b0;
  endtask

  task automatic run_round(input rec_t r);
    exp_t e;
    wait_stim();
    e.res  = r.res;
    e.best = r.best;
    sb.push_back(e);
    press_at(r.lat);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && !done; i++) @(negedge clk);
    check("done", 32'(done), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  rec_t tbl[8];
  bit   stim_seen;

  initial begin
    rst = 1'b1; start_trigger = 1'b0; user_trigger = 1'b0;
    tbl[0] = '{10, 14'd10, 14'd10};
    tbl[1] = '{10, 14'd10, 14'd10};
    tbl[2] = '{10, 14'd10, 14'd10};
    tbl[3] = '{10, 14'd10, 14'd10};
    tbl[4] = '{12, 14'd12, 14'd12};
    tbl[5] = '{7,  14'd7,  14'd7};
    tbl[6] = '{15, 14'd15, 14'd7};
    tbl[7] = '{9,  14'd9,  14'd7};

    cyc(3);
    check("reset_flags", 32'({meas_clear, meas_run, stimulus_on, result_valid,
                              false_start, timeout, busy, done}), 32'd0);
    check("reset_result", 32'(result_ms), 32'd0);
    check("reset_best", 32'(best_ms), 32'h3FFF);
    check("reset_round", 32'(round_idx), 32'd0);
    rst = 1'b0;
    cyc(3);
    check("idle_busy", 32'(busy), 32'd0);

    // Normal session then best-tracking session
    for (int i = 0; i < 8; i++) begin
      if (i % 4 == 0) pulse_start();
      run_round(tbl[i]);
      if (i % 4 == 3) begin
        wait_done();
        check("session_round_idx", 32'(round_idx), 32'd3);
        check("session_best", 32'(best_ms), 32'(tbl[i].best));
`ifdef AVERAGE_EN
        check("avg_ms", 32'(avg_ms), 32'd10);
`endif
      end
    end

    // False start in round 1
    pulse_start();
    run_round('{5, 14'd5, 14'd5});
    for (int i = 0; i < 200 && !meas_clear; i++) @(negedge clk);
    @(negedge clk) user_trigger = 1'b1;
    @(negedge clk);
    check("fs_flag", 32'(false_start), 32'd1);
    check("fs_busy", 32'(busy), 32'd0);
    check("fs_round", 32'(round_idx), 32'd1);
    stim_seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (stimulus_on) stim_seen = 1'b1;
    end
    check("fs_no_stimulus", 32'(stim_seen), 32'd0);
    user_trigger = 1'b0;
    pulse_start();
    check("fs_cleared", 32'(false_start), 32'd0);
    check("fs_rerun_round", 32'(round_idx), 32'd1);
    run_round('{6, 14'd6, 14'd5});

    // Timeout in round 2
    wait_stim();
    for (int i = 0; i < 200 && !timeout; i++) @(negedge clk);
    check("to_flag", 32'(timeout), 32'd1);
    check("to_meas_run", 32'(meas_run), 32'd0);
    check("to_stimulus", 32'(stimulus_on), 32'd0);
    check("to_meas_ms", 32'(meas_ms), 32'd20);
    check("to_round", 32'(round_idx), 32'd2);

    // Button held through the foreperiod: no false start, no capture until re-press
    @(negedge clk) user_trigger = 1'b1;
    cyc(2);
    pulse_start();
    check("held_flags_cleared", 32'(timeout), 32'd0);
    wait_stim();
    check("held_no_false_start", 32'(false_start), 32'd0);
    cyc(8);
    check("held_no_capture", 32'(stimulus_on), 32'd1);
    user_trigger = 1'b0;
    cyc(1);
    run_round('{8, 14'd8, 14'd5});

    // Reset during REACT of round 3
    wait_stim();
    cyc(4);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs", 32'({meas_run, stimulus_on, busy, done, false_start, timeout}), 32'd0);
    check("rst_best", 32'(best_ms), 32'h3FFF);
    check("rst_round", 32'(round_idx), 32'd0);
    rst = 1'b0;
    cyc(3);
    pulse_start();
    check("restart_busy", 32'(busy), 32'd1);
    check("restart_round", 32'(round_idx), 32'd0);
    run_round('{3, 14'd3, 14'd3});

    cyc(20);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
